// File: rtl/decode_pkg.sv
// Shared decode types and the code -> one-hot mapping, also used by the encoder tests.
// Code c sets bit (7-c): 3'b111 -> 8'h01, 3'b000 -> 8'h80.
package decode_pkg;
  localparam int CODE_W   = 3;
  localparam int ONEHOT_W = 8;

  typedef logic [CODE_W-1:0]   code_t;
  typedef logic [ONEHOT_W-1:0] onehot_t;

  function automatic onehot_t decode38(input code_t code);
    return onehot_t'(1) << (CODE_W'(7) - code);
  endfunction
endpackage

// File: rtl/decode_38_buf_if.sv
// Code-in / one-hot-out handshake bundle; master is the producer/consumer side, slave is the decoder.
interface decode_38_buf_if #(parameter int CNT_W = 16);
  import decode_pkg::*;

  logic             in_valid;
  logic             in_ready;
  code_t            in_code;
  logic             out_valid;
  logic             out_ready;
  onehot_t          out_onehot;
  logic [CNT_W-1:0] xfer_cnt;

  modport master (
    output in_valid, in_code, out_ready,
    input  in_ready, out_valid, out_onehot, xfer_cnt
  );

  modport slave (
    input  in_valid, in_code, out_ready,
    output in_ready, out_valid, out_onehot, xfer_cnt
  );
endinterface

// File: rtl/code_fifo.sv
// Small code FIFO: push/pop with head look-ahead, 0-cycle head visibility after write edge.
// Caller must not push when full nor pop when empty; count is 0..DEPTH.
module code_fifo #(
  parameter  int DEPTH = 2,
  parameter  int W     = 3,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/decode_38_buf.sv
// Buffered 3-to-8 decoder; 1-cycle accept->out_valid when empty, 1 word/cycle, capacity DEPTH+1.
// in_ready comes from registered FIFO occupancy only; the output holds stable while stalled.
module decode_38_buf #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  decode_38_buf_if.slave bus
);
  import decode_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]    fifo_count;
  code_t            fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             accept;
  logic             load;
  logic             pop;
  logic             push;
  logic             bypass;
  logic             out_vld_q;
  onehot_t          out_dat_q;
  logic [CNT_W-1:0] cnt_q;

  assign bus.in_ready = (fifo_count < CW'(DEPTH));
  assign accept       = bus.in_valid && bus.in_ready;
  assign load         = !out_vld_q || bus.out_ready;
  assign pop          = load && !fifo_empty;
  // An empty FIFO lets an accepted code skip straight into the output register.
  assign bypass       = load && fifo_empty && accept;
  assign push         = accept && !bypass;

  code_fifo #(.DEPTH(DEPTH), .W(CODE_W)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (bus.in_code),
    .pop      (pop),
    .head     (fifo_head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      cnt_q     <= '0;
    end else begin
      if (load) begin
        if (pop) begin
          out_vld_q <= 1'b1;
          out_dat_q <= decode38(fifo_head);
        end else if (bypass) begin
          out_vld_q <= 1'b1;
          out_dat_q <= decode38(bus.in_code);
        end else begin
          out_vld_q <= 1'b0;
          out_dat_q <= '0;
        end
      end
      if (out_vld_q && bus.out_ready) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.out_valid  = out_vld_q;
  assign bus.out_onehot = out_dat_q;
  assign bus.xfer_cnt   = cnt_q;
endmodule

// File: tb/tb_decode_38_buf.sv
// Randomized bench for decode_38_buf against a queue-based model of the (DEPTH+1)-word buffer.
module tb_decode_38_buf;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  decode_38_buf_if #(.CNT_W(16)) bus ();
  decode_38_buf_if #(.CNT_W(4))  bus4 ();

  decode_38_buf #(.DEPTH(DEPTH), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  decode_38_buf #(.DEPTH(DEPTH), .CNT_W(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  int checks = 0;
  int failures = 0;

  logic [7:0]  q[$];
  int unsigned xfers = 0;
  bit          last_acc;
  bit          use_orig = 0;
  logic [7:0]  orig_byte;

  // Reference encoder: one-hot byte -> code (7 - bit position); non-one-hot -> 0.
  function automatic logic [2:0] enc(input logic [7:0] b);
    for (int p = 0; p < 8; p++)
      if (b == (8'h01 << p)) return 3'(7 - p);
    return 3'd0;
  endfunction

  // Advance one clock; the model holds every accepted word until it is transferred.
  task automatic tick();
    bit acc, xf;
    logic [7:0] w;
    acc = bus.in_valid && (q.size() <= DEPTH);
    xf  = bus.out_ready && (q.size() > 0);
    w   = use_orig ? orig_byte : (8'h80 >> bus.in_code);
    @(posedge clk);
    if (xf) begin
      q.delete(0);
      xfers++;
    end
    if (acc) q.push_back(w);
    last_acc = acc;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.in_code = 0; bus.out_ready = 0;
    bus4.in_valid = 0; bus4.in_code = 0; bus4.out_ready = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_onehot !== 8'h00) begin failures++; $display("FAIL reset_onehot got=%h exp=00", bus.out_onehot); end
    checks++; if (bus.xfer_cnt !== 16'd0) begin failures++; $display("FAIL reset_xfer got=%0d exp=0", bus.xfer_cnt); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_single();
    bus.in_valid = 1; bus.in_code = 3'b111; bus.out_ready = 0;
    tick();
    bus.in_valid = 0;
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_onehot !== 8'h01) begin failures++; $display("FAIL single_onehot got=%h exp=01", bus.out_onehot); end
    checks++; if (bus.xfer_cnt !== 16'd0) begin failures++; $display("FAIL single_xfer_pre got=%0d exp=0", bus.xfer_cnt); end
    bus.out_ready = 1;
    tick();
    checks++; if (bus.xfer_cnt !== 16'd1) begin failures++; $display("FAIL single_xfer got=%0d exp=1", bus.xfer_cnt); end
    checks++; if (bus.out_valid !== 1'b0 || bus.out_onehot !== 8'h00) begin failures++; $display("FAIL single_drain got=%b/%h exp=0/00", bus.out_valid, bus.out_onehot); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [8];
    exp = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    bus.out_ready = 1;
    for (int c = 0; c < 8; c++) begin
      bus.in_valid = 1; bus.in_code = 3'(c);
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready code=%0d got=%b exp=1", c, bus.in_ready); end
      tick();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_onehot !== exp[c]) begin failures++; $display("FAIL b2b_out code=%0d got=%b/%h exp=1/%h", c, bus.out_valid, bus.out_onehot, exp[c]); end
    end
    bus.in_valid = 0;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_full_stall();
    logic [2:0] codes [3];
    logic [7:0] exp [4];
    codes = '{3'd5, 3'd4, 3'd3};
    exp   = '{8'h04, 8'h08, 8'h10, 8'h20};
    bus.out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1; bus.in_code = codes[i];
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL stall_accept i=%0d got=%b exp=1", i, bus.in_ready); end
      tick();
    end
    bus.in_code = 3'd2;
    for (int i = 0; i < 2; i++) begin
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL stall_full got=%b exp=0", bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b1 || bus.out_onehot !== 8'h04) begin failures++; $display("FAIL stall_hold got=%b/%h exp=1/04", bus.out_valid, bus.out_onehot); end
      tick();
    end
    bus.out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.out_onehot !== exp[i]) begin failures++; $display("FAIL stall_drain i=%0d got=%h exp=%h", i, bus.out_onehot, exp[i]); end
      tick();
      if (last_acc) bus.in_valid = 0;
    end
    checks++; if (bus.out_valid !== 1'b0 || q.size() != 0) begin failures++; $display("FAIL stall_empty got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1; bus.in_code = 3'($urandom_range(0, 7));
      tick();
    end
    bus.in_valid = 0;
    #2 rst_n = 0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_onehot !== 8'h00) begin failures++; $display("FAIL rstmid_onehot got=%h exp=00", bus.out_onehot); end
    checks++; if (bus.xfer_cnt !== 16'd0) begin failures++; $display("FAIL rstmid_xfer got=%0d exp=0", bus.xfer_cnt); end
    q.delete();
    xfers = 0;
    @(negedge clk);
    rst_n = 1;
    bus.out_ready = 1;
    tick();
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0 || bus.out_onehot !== 8'h00) begin failures++; $display("FAIL rstmid_stale got=%b/%h exp=0/00", bus.out_valid, bus.out_onehot); end
  endtask

  task automatic test_encoder_chain();
    use_orig = 1;
    for (int n = 0; n < 400; n++) begin
      checks++;
      if (bus.out_valid !== (q.size() > 0) || bus.in_ready !== (q.size() <= DEPTH) ||
          bus.out_onehot !== ((q.size() > 0) ? q[0] : 8'h00) || bus.xfer_cnt !== 16'(xfers)) begin
        failures++;
        $display("FAIL enc_chain n=%0d got v=%b r=%b d=%h c=%0d exp v=%b r=%b d=%h c=%0d", n,
                 bus.out_valid, bus.in_ready, bus.out_onehot, bus.xfer_cnt,
                 q.size() > 0, q.size() <= DEPTH, (q.size() > 0) ? q[0] : 8'h00, 16'(xfers));
      end
      orig_byte     = 8'h01 << $urandom_range(0, 7);
      bus.in_code   = enc(orig_byte);
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    use_orig = 0;
    bus.in_valid = 0; bus.out_ready = 1;
    for (int i = 0; i < 8 && q.size() > 0; i++) tick();
    bus.in_valid = 1; bus.in_code = enc(8'h03);
    tick();
    bus.in_valid = 0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_onehot !== 8'h80) begin failures++; $display("FAIL enc_fault got=%b/%h exp=1/80", bus.out_valid, bus.out_onehot); end
    tick();
  endtask

  task automatic test_wrap();
    bus4.out_ready = 1; bus4.in_valid = 1;
    for (int i = 0; i < 17; i++) begin
      bus4.in_code = 3'($urandom_range(0, 7));
      @(posedge clk);
      @(negedge clk);
    end
    bus4.in_valid = 0;
    repeat (3) @(negedge clk);
    checks++; if (bus4.xfer_cnt !== 4'(17 % 16)) begin failures++; $display("FAIL wrap_xfer got=%0d exp=%0d", bus4.xfer_cnt, 17 % 16); end
    bus4.out_ready = 0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 10000; n++) begin
      checks++;
      if (bus.out_valid !== (q.size() > 0) || bus.in_ready !== (q.size() <= DEPTH) ||
          bus.out_onehot !== ((q.size() > 0) ? q[0] : 8'h00) || bus.xfer_cnt !== 16'(xfers)) begin
        failures++;
        $display("FAIL random n=%0d got v=%b r=%b d=%h c=%0d exp v=%b r=%b d=%h c=%0d", n,
                 bus.out_valid, bus.in_ready, bus.out_onehot, bus.xfer_cnt,
                 q.size() > 0, q.size() <= DEPTH, (q.size() > 0) ? q[0] : 8'h00, 16'(xfers));
      end
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_code   = 3'($urandom_range(0, 7));
      bus.out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    bus.in_valid = 0; bus.out_ready = 1;
    for (int i = 0; i < 8 && q.size() > 0; i++) tick();
    checks++; if (bus.out_valid !== 1'b0 || q.size() != 0) begin failures++; $display("FAIL random_drain got=%b exp=0", bus.out_valid); end
    checks++; if (bus.xfer_cnt !== 16'(xfers)) begin failures++; $display("FAIL random_xfer got=%0d exp=%0d", bus.xfer_cnt, 16'(xfers)); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_stall();
    test_reset_mid();
    test_encoder_chain();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
